// File: rtl/synapse_accumulator_if.sv
// Bus between the synapse accumulator and its driver: tick/spike input,
// weight-table write port and the current/valid result to the neuron.
interface synapse_accumulator_if #(
    parameter int N_INPUTS = 8,
    parameter int AW       = 3
);
    logic                tick;
    logic [N_INPUTS-1:0] spikes_in;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [7:0]          wr_data;
    logic [7:0]          current;
    logic                current_valid;
    logic                busy;
    logic                tick_dropped;

    modport master (
        output tick, spikes_in, wr_en, wr_addr, wr_data,
        input  current, current_valid, busy, tick_dropped
    );

    modport slave (
        input  tick, spikes_in, wr_en, wr_addr, wr_data,
        output current, current_valid, busy, tick_dropped
    );
endinterface

// File: rtl/synapse_accumulator.sv
// Sequential weighted spike summation: one input per clock into a wide signed
// accumulator, saturated once to an 8-bit unsigned current at the end.
module synapse_accumulator #(
    parameter int N_INPUTS = 8,
    parameter int AW       = 3,
    parameter int ACC_W    = 12
) (
    input  logic clk,
    input  logic rst,
    synapse_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t              state_q, state_d;
    logic [7:0]          weight_q [N_INPUTS];
    logic [N_INPUTS-1:0] spk_q;
    logic [ACC_W-1:0]    acc_q;
    logic [AW-1:0]       idx_q;
    logic [7:0]          current_q;
    logic                valid_q;
    logic                dropped_q;
    logic [7:0]          w_cur;
    logic [7:0]          clamp_val;

    // Weight read for the input currently being added (pre-write value).
    assign w_cur = weight_q[idx_q];

    // Saturate the final sum: negative -> 0, above 255 -> 255.
    always_comb begin
        clamp_val = acc_q[7:0];
        if (acc_q[ACC_W-1])
            clamp_val = 8'd0;
        else if (|acc_q[ACC_W-2:8])
            clamp_val = 8'hFF;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.tick) state_d = ACCUM;
            ACCUM:   if (idx_q == AW'(N_INPUTS - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Weight table; writes land in any state, reads in the same cycle see the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_INPUTS; i++) weight_q[i] <= 8'd0;
        end else if (bus.wr_en) begin
            weight_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Accumulation datapath, result register and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spk_q     <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            current_q <= 8'd0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            dropped_q <= bus.tick && (state_q != IDLE);
            case (state_q)
                IDLE: if (bus.tick) begin
                    spk_q <= bus.spikes_in;
                    acc_q <= '0;
                    idx_q <= '0;
                end
                ACCUM: begin
                    if (spk_q[idx_q])
                        acc_q <= acc_q + {{(ACC_W-8){w_cur[7]}}, w_cur};
                    idx_q <= idx_q + AW'(1);
                end
                DONE: begin
                    current_q <= clamp_val;
                    valid_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.current       = current_q;
    assign bus.current_valid = valid_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.tick_dropped  = dropped_q;
endmodule

// File: tb/tb_synapse_accumulator.sv
// Self-checking bench: table vectors, random runs against a sum-and-clamp
// model, and hand sequences for dropped ticks, mid-run writes and reset.
module tb_synapse_accumulator;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    synapse_accumulator_if #(.N_INPUTS(N), .AW(3)) bus ();

    synapse_accumulator #(.N_INPUTS(N), .AW(3), .ACC_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         w [N];
        logic [7:0] spk;
        int         exp;
    } vec_t;

    vec_t vecs [6];
    int   wmodel [N];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic write_w(input int a, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(a);
        bus.wr_data = 8'(d);
        step();
        bus.wr_en   = 1'b0;
        wmodel[a]   = d;
    endtask

    // Reference: plain integer sum of active weights, clamped to 0..255.
    function automatic int model(input logic [7:0] spk);
        int s = 0;
        for (int i = 0; i < N; i++) if (spk[i]) s += wmodel[i];
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    // Issue a tick, wait (bounded) for valid, check latency, busy span and value.
    task automatic run(input logic [7:0] spk, input int exp, input string name,
                       input bit chk_timing);
        int lat, busy_n;
        bus.tick      = 1'b1;
        bus.spikes_in = spk;
        step();
        bus.tick      = 1'b0;
        lat = 0; busy_n = 0;
        while (!bus.current_valid && lat < 30) begin
            if (bus.busy) busy_n++;
            step();
            lat++;
        end
        if (lat >= 30) check({name, "_timeout"}, lat, N + 1);
        else begin
            if (chk_timing) begin
                check({name, "_latency"}, lat, N + 1);
                check({name, "_busy_cycles"}, busy_n, N + 1);
            end
            check({name, "_current"}, int'(bus.current), exp);
        end
        step();
        check({name, "_valid_one_cycle"}, int'(bus.current_valid), 0);
    endtask

    initial begin
        bus.tick = 1'b0; bus.spikes_in = '0; bus.wr_en = 1'b0;
        bus.wr_addr = '0; bus.wr_data = '0;
        for (int i = 0; i < N; i++) wmodel[i] = 0;

        vecs[0].w = '{10, 20, 30, 40, 50, 60, 70, 80};         vecs[0].spk = 8'h05; vecs[0].exp = 40;
        vecs[1].w = '{100, 100, 100, 100, 100, 100, 100, 100}; vecs[1].spk = 8'hFF; vecs[1].exp = 255;
        vecs[2].w = '{-100, -100, -100, -100, -100, -100, -100, -100}; vecs[2].spk = 8'hFF; vecs[2].exp = 0;
        vecs[3].w = '{120, 120, -100, 0, 0, 0, 0, 0};          vecs[3].spk = 8'h07; vecs[3].exp = 140;
        vecs[4].w = '{10, 20, 30, 40, 50, 60, 70, 80};         vecs[4].spk = 8'h00; vecs[4].exp = 0;
        vecs[5].w = '{10, 20, 30, 40, 50, 60, 70, 80};         vecs[5].spk = 8'h80; vecs[5].exp = 80;

        // Reset state
        step(); step();
        check("rst_current", int'(bus.current), 0);
        check("rst_valid", int'(bus.current_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_dropped", int'(bus.tick_dropped), 0);
        rst = 1'b0;
        step();

        // Table vectors
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < N; i++) write_w(i, vecs[v].w[i]);
            run(vecs[v].spk, vecs[v].exp, $sformatf("vec%0d", v), 1'b1);
        end

        // Random runs against the model
        for (int r = 0; r < 20; r++) begin
            logic [7:0] spk;
            for (int i = 0; i < N; i++) write_w(i, int'($urandom_range(255)) - 128);
            spk = 8'($urandom);
            run(spk, model(spk), $sformatf("rand%0d", r), 1'b0);
        end

        // Dropped ticks: ticks at t, t+3, t+9 (dropped in DONE), t+10 (accepted)
        for (int i = 0; i < N; i++) write_w(i, (i == 0) ? 5 : 0);
        bus.tick = 1'b1; bus.spikes_in = 8'h01;
        step();
        for (int k = 1; k <= 20; k++) begin
            bus.tick      = (k == 3 || k == 9 || k == 10);
            bus.spikes_in = (k == 10) ? 8'h01 : 8'h00;
            step();
            check($sformatf("drop_pulse_k%0d", k), int'(bus.tick_dropped),
                  (k == 3 || k == 9) ? 1 : 0);
            check($sformatf("drop_valid_k%0d", k), int'(bus.current_valid),
                  (k == 9 || k == 19) ? 1 : 0);
            if (k == 9 || k == 19)
                check($sformatf("drop_current_k%0d", k), int'(bus.current), 5);
        end
        bus.tick = 1'b0;
        step();

        // Mid-run write: rewrite w3 while idx==3 is being added
        for (int i = 0; i < N; i++) write_w(i, (i == 3) ? 7 : 0);
        bus.tick = 1'b1; bus.spikes_in = 8'h08;
        step();
        bus.tick = 1'b0;
        step(); step(); step();
        bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 8'd50;
        step();
        bus.wr_en = 1'b0; wmodel[3] = 50;
        begin
            int n = 0;
            while (!bus.current_valid && n < 20) begin step(); n++; end
            check("midwrite_seen", int'(bus.current_valid), 1);
            check("midwrite_old", int'(bus.current), 7);
        end
        step();
        run(8'h08, 50, "midwrite_new", 1'b1);

        // Async reset in the middle of an accumulation
        bus.tick = 1'b1; bus.spikes_in = 8'h08;
        step();
        bus.tick = 1'b0;
        step(); step(); step(); step();
        check("prereset_busy", int'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_current", int'(bus.current), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        check("async_rst_valid", int'(bus.current_valid), 0);
        step();
        rst = 1'b0;
        begin
            int seen = 0;
            for (int k = 0; k < 12; k++) begin
                if (bus.current_valid || bus.busy) seen++;
                step();
            end
            check("post_rst_quiet", seen, 0);
        end
        for (int i = 0; i < N; i++) wmodel[i] = 0;
        run(8'hFF, 0, "post_rst_cleared", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
